// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor slice.
//   state_t      : two-state controller encoding (IDLE, RUN)
//   calc_steps   : number of RUN cycles needed for a WIDTH/DIGIT pair
//   digit_fits   : elaboration-time legality test for a WIDTH/DIGIT pair
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // WIDTH must be at least 2 and an exact multiple of DIGIT.
  function automatic bit digit_fits(input int width, input int digit);
    return (digit > 0) && (width >= 2) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//   start, A, B, Bin : request and operands (driven by the master)
//   busy, done       : operation in progress / one-cycle completion pulse
//   D, Br, V, Z      : difference, borrow-out, signed overflow, zero flag
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  import serial_sub_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Br;
  logic             V;
  logic             Z;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Br, V, Z
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Br, V, Z
  );

endinterface

// File: rtl/serial_subtractor_digit.sv
// sub_digit: purely combinational DIGIT-bit ripple-borrow subtractor slice.
//   a, b : DIGIT-bit minuend / subtrahend slice
//   bi   : borrow into the least significant bit of the slice
//   d    : DIGIT-bit difference slice
//   bo   : borrow out of the most significant bit of the slice
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);
  import serial_sub_pkg::*;

  logic bw;

  always_comb begin
    bw = bi;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    bo = bw;
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle D = A - B - Bin over WIDTH bits, DIGIT bits
// per clock starting at the LSB, with the ripple borrow held in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if
//           start/A/B/Bin in; busy/done/D/Br/V/Z out
// A start seen in IDLE is accepted; STEPS edges later done pulses for one
// cycle and D/Br/V/Z update together. Outputs never show partial results.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  generate
    if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
    if ($bits(bus.D) != WIDTH) begin : g_bad_bus
      $error("serial_subtractor: interface WIDTH does not match module WIDTH");
    end
  endgenerate

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [WIDTH-1:0]   a_q, a_nxt;
  logic [WIDTH-1:0]   b_q, b_nxt;
  logic               brw_q, brw_nxt;
  logic [WIDTH-1:0]   work_q, work_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [WIDTH-1:0]   d_q, d_nxt;
  logic               br_q, br_nxt;
  logic               v_q, v_nxt;
  logic               z_q, z_nxt;

  logic [IDX_W-1:0]   base;
  logic [DIGIT-1:0]   slice_d;
  logic               slice_bo;
  logic [WIDTH-1:0]   work_step;

  // Bit offset of the digit being processed this cycle.
  assign base = IDX_W'(cnt_q * DIGIT);

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a  (a_q[base +: DIGIT]),
    .b  (b_q[base +: DIGIT]),
    .bi (brw_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // Working result with the current digit merged in; on the last step this
  // is the complete difference, which lets D/V/Z update on the same edge.
  always_comb begin
    work_step = work_q;
    work_step[base +: DIGIT] = slice_d;
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    brw_nxt   = brw_q;
    work_nxt  = work_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    d_nxt     = d_q;
    br_nxt    = br_q;
    v_nxt     = v_q;
    z_nxt     = z_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.A;
          b_nxt     = bus.B;
          brw_nxt   = bus.Bin;
          cnt_nxt   = '0;
          work_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        work_nxt = work_step;
        brw_nxt  = slice_bo;
        cnt_nxt  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cnt_nxt   = '0;
          d_nxt     = work_step;
          br_nxt    = slice_bo;
          v_nxt     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                      (a_q[WIDTH-1] ^ work_step[WIDTH-1]);
          z_nxt     = ~|work_step;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      br_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      brw_q   <= brw_nxt;
      work_q  <= work_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      d_q     <= d_nxt;
      br_q    <= br_nxt;
      v_q     <= v_nxt;
      z_q     <= z_nxt;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Br   = br_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4 instances.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       br;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic br, output logic v, output logic z);
    longint ua, ub, diff, sa, sb, sd, modv, half;
    modv = longint'(1) << w;
    half = longint'(1) << (w - 1);
    ua   = longint'(a);
    ub   = longint'(b);
    diff = ua - ub - longint'(bin);
    br   = (diff < 0);
    if (diff < 0) diff = diff + modv;
    d    = 16'(diff);
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    sd   = sa - sb - longint'(bin);
    v    = (sd < -half) || (sd > half - 1);
    z    = (d == 16'h0);
  endtask

  // Runs one 8-bit operation; lat counts edges from accept to done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic br, output logic v, output logic z,
                      output int lat, output logic held, output logic busy_ok);
    logic [7:0] prev;
    @(negedge clk);
    prev = if8.D;
    if8.A = a; if8.B = b; if8.Bin = bin; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.A = 8'($urandom); if8.B = 8'($urandom); if8.Bin = 1'($urandom);
    held = 1'b1;
    busy_ok = if8.busy;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (if8.done) break;
      if (if8.D !== prev) held = 1'b0;
      if (lat < 8 && if8.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (if8.busy !== 1'b0) busy_ok = 1'b0;
    d = if8.D; br = if8.Br; v = if8.V; z = if8.Z;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic br, output logic v, output logic z,
                       output int lat);
    @(negedge clk);
    if16.A = a; if16.B = b; if16.Bin = bin; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    if16.A = 16'($urandom); if16.B = 16'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (if16.done) break;
    end
    d = if16.D; br = if16.Br; v = if16.V; z = if16.Z;
  endtask

  initial begin
    logic [7:0]  d8;
    logic [15:0] d16, md;
    logic        br, v, z, held, busy_ok, mbr, mv, mz;
    int          lat, dones;
    logic [15:0] ra, rb;
    logic        rbin;

    total_cnt = 0;
    pass_cnt  = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

    if8.start = 1'b0;  if8.A = '0;  if8.B = '0;  if8.Bin = 1'b0;
    if16.start = 1'b0; if16.A = '0; if16.B = '0; if16.Bin = 1'b0;

    rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_done", 32'(if8.done), 32'd0);
    check("rst_D",    32'(if8.D),    32'd0);
    check("rst_flags", {29'd0, if8.Br, if8.V, if8.Z}, 32'd0);
    check("rst_D16",  32'(if16.D),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table, WIDTH=8 DIGIT=1.
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].bin, d8, br, v, z, lat, held, busy_ok);
      check($sformatf("v%0d_lat", i),  32'(lat), 32'd8);
      check($sformatf("v%0d_D", i),    32'(d8),  32'(vecs[i].d));
      check($sformatf("v%0d_Br", i),   32'(br),  32'(vecs[i].br));
      check($sformatf("v%0d_V", i),    32'(v),   32'(vecs[i].v));
      check($sformatf("v%0d_Z", i),    32'(z),   32'(vecs[i].z));
      check($sformatf("v%0d_hold", i), 32'(held), 32'd1);
      check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
    end

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    if8.A = 8'h00; if8.B = 8'h00; if8.Bin = 1'b1; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    dones = 0;
    repeat (2) begin @(posedge clk); #1; if (if8.done) dones++; end
    @(negedge clk);
    if8.A = 8'h10; if8.B = 8'h00; if8.Bin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if (if8.done) dones++;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (if8.done) dones++; end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_D", 32'(if8.D), 32'hFF);
    check("ign_Br", 32'(if8.Br), 32'd1);
    check("ign_busy", 32'(if8.busy), 32'd0);

    // Back-to-back with start held across the done cycle.
    @(negedge clk);
    if8.A = 8'h05; if8.B = 8'h03; if8.Bin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.A = 8'h80; if8.B = 8'h01;
    lat = 0;
    while (lat < 20) begin @(posedge clk); #1; lat++; if (if8.done) break; end
    check("b2b_lat1", 32'(lat), 32'd8);
    check("b2b_D1", 32'(if8.D), 32'h02);
    @(posedge clk); #1;
    check("b2b_busy2", 32'(if8.busy), 32'd1);
    check("b2b_done_off", 32'(if8.done), 32'd0);
    if8.start = 1'b0;
    lat = 0;
    while (lat < 20) begin @(posedge clk); #1; lat++; if (if8.done) break; end
    check("b2b_lat2", 32'(lat), 32'd8);
    check("b2b_D2", 32'(if8.D), 32'h7F);
    check("b2b_V2", 32'(if8.V), 32'd1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    if8.A = 8'h55; if8.B = 8'h11; if8.Bin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(if8.busy), 32'd0);
    check("arst_D", 32'(if8.D), 32'd0);
    check("arst_flags", {29'd0, if8.Br, if8.V, if8.Z}, 32'd0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (if8.done) dones++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (if8.done) dones++; end
    check("arst_nodone", 32'(dones), 32'd0);
    run8(8'h10, 8'h01, 1'b0, d8, br, v, z, lat, held, busy_ok);
    check("arst_after_D", 32'(d8), 32'h0F);
    check("arst_after_lat", 32'(lat), 32'd8);

    // WIDTH=16 DIGIT=4.
    run16(16'h1000, 16'h0001, 1'b0, d16, br, v, z, lat);
    check("w16_lat", 32'(lat), 32'd4);
    check("w16_D", 32'(d16), 32'h0FFF);
    check("w16_Br", 32'(br), 32'd0);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(8, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, rbin, md, mbr, mv, mz);
      run8(ra[7:0], rb[7:0], rbin, d8, br, v, z, lat, held, busy_ok);
      check($sformatf("r8_%0d", i), {lat[7:0], 3'd0, z, v, br, d8, 8'h00},
                                    {8'd8, 3'd0, mz, mv, mbr, md[7:0], 8'h00});
      model(16, ra, rb, rbin, md, mbr, mv, mz);
      run16(ra, rb, rbin, d16, br, v, z, lat);
      check($sformatf("r16_%0d", i), {lat[7:0], 5'd0, z, v, br, d16},
                                     {8'd4, 5'd0, mz, mv, mbr, md});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
